maxnet: RTL and testbench
=========================

MAXNET -- requirements
Module: maxnet

Interface
REQ-001 Parameter N, default 5, SHALL set the number of competing neurons; it equals the result width.
REQ-002 Parameter W, default 8, SHALL set the unsigned activation width in bits.
REQ-003 Parameter EPS_SHIFT, default 3, SHALL set the inhibition weight to eps = 2^-EPS_SHIFT (1/8 by default).
REQ-004 Parameter MAX_ITER, default 63, SHALL set the maximum number of update iterations per run.
REQ-005 Parameter INIT, default {20,35,60,45,10} (neuron 0..4, W bits each), SHALL hold the initial activations.
REQ-006 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 Port start, input, 1 bit: run request, sampled level-sensitively in IDLE and DONE only.
REQ-009 Port done, output, 1 bit: high while a finished result is valid.
REQ-010 Port result, output, N bits: one-hot winner mask, bit i set means neuron i survived.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, LOAD, ITER and DONE.
REQ-012 In IDLE, start=1 SHALL move the FSM to LOAD; otherwise it stays in IDLE.
REQ-013 LOAD SHALL copy INIT into the activation registers a[0..N-1], clear the iteration counter, and go to ITER.
REQ-014 Each ITER cycle SHALL first evaluate the termination condition on the current a[]: nonzero count <= 1, or counter == MAX_ITER.
REQ-015 If the termination condition holds, the FSM SHALL go to DONE and register result[i] = (a[i] != 0).
REQ-016 Otherwise, in that same ITER cycle, all neurons SHALL update simultaneously, a[i] <= max(0, a[i] - ((S - a[i]) >> EPS_SHIFT)), where S is the sum of all a[].
REQ-017 The counter SHALL increment on each update.
REQ-018 S SHALL be computed at width W+3 bits so it cannot overflow.
REQ-019 The subtraction SHALL be signed, or compare-then-subtract, so that any negative result clamps to 0; activations never wrap.
REQ-020 In DONE, done SHALL be 1 and result SHALL stay stable.
REQ-021 In DONE, start=1 SHALL go to LOAD and begin a new run, with done dropping to 0 on that edge.
REQ-022 In DONE, start=0 SHALL keep the FSM in DONE.
REQ-023 start SHALL be ignored in LOAD and ITER; holding start high across a whole run SHALL cause a rerun after DONE, lasting one DONE cycle.
REQ-024 done SHALL be 0 in every state other than DONE.
REQ-025 result SHALL keep its last value outside DONE and be overwritten only on entry to DONE.
REQ-026 If all activations reach 0 (a tie decays away), result SHALL be all zeros with done=1.
REQ-027 If MAX_ITER is reached, result MAY have several bits set (unresolved tie) and SHALL reflect the surviving neurons.
REQ-028 Latency from start sampled in IDLE to done=1 SHALL be 2 + k cycles, where k is the number of updates performed.

Reset
REQ-029 When rst=1 at a clock edge, the FSM SHALL go to IDLE and done, result, a[] and the counter SHALL all be 0.
REQ-030 rst SHALL take priority over start and abort any run in progress mid-operation.
REQ-031 After rst is released, the block SHALL wait for a new start.

Structure
REQ-032 A shared package maxnet_pkg SHALL hold the state enum typedef and the default constants (N, W, EPS_SHIFT, MAX_ITER, INIT).
REQ-033 A sub-module maxnet_neuron (one per neuron, generate-instantiated) SHALL compute the clamped update of one activation from a[i] and S.
REQ-034 The top level SHALL hold the FSM, the sum adder tree, the counter and the nonzero counter.
REQ-035 No multiplier SHALL be used; eps is a shift only.

Verification
REQ-036 Default INIT, start held high for 3 cycles from reset -> done=1, result=5'b00100; a single run completes and done is held.
REQ-037 INIT={50,50,10,0,0} with MAX_ITER=63 -> done=1, result=5'b00011 (tie survives) or 5'b00000 if it decays; the bench checks against a reference model.
REQ-038 INIT={0,0,0,0,40} -> done=1 after exactly 2 cycles (k=0), result=5'b10000.
REQ-039 rst=1 asserted mid-ITER -> next edge done=0, result=0, FSM in IDLE; a subsequent start gives the default result 5'b00100.
REQ-040 start pulsed in DONE -> done drops for the rerun, then returns with an identical result.
REQ-041 A random INIT sweep is checked against a cycle-accurate model of REQ-016, comparing result and latency.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared types and default constants for the MAXNET winner-take-all block.
package maxnet_pkg;

    localparam int DEF_N         = 5;
    localparam int DEF_W         = 8;
    localparam int DEF_EPS_SHIFT = 3;
    localparam int DEF_MAX_ITER  = 63;

    // Neuron 0 sits in the least significant W bits.
    localparam logic [DEF_N*DEF_W-1:0] DEF_INIT = {8'd10, 8'd45, 8'd60, 8'd35, 8'd20};

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_DONE
    } state_t;

endpackage

// File: rtl/maxnet_neuron.sv
// One MAXNET neuron: clamped lateral-inhibition update of a single activation.
// Inhibition is (S - a) >> EPS_SHIFT; the result clamps at zero instead of wrapping.
module maxnet_neuron
    import maxnet_pkg::*;
#(
    parameter int W         = DEF_W,
    parameter int SW        = DEF_W + 3,
    parameter int EPS_SHIFT = DEF_EPS_SHIFT
) (
    input  logic [W-1:0]  a_i,
    input  logic [SW-1:0] sum_i,
    output logic [W-1:0]  a_next_o
);

    logic [SW-1:0] a_ext;
    logic [SW-1:0] others;
    logic [SW-1:0] inhib;
    logic [SW-1:0] diff;

    assign a_ext  = {{(SW-W){1'b0}}, a_i};
    // S always contains a_i, so this never underflows.
    assign others = sum_i - a_ext;
    assign inhib  = others >> EPS_SHIFT;
    assign diff   = a_ext - inhib;
    // Compare first, subtract only when the result stays non-negative.
    assign a_next_o = (inhib >= a_ext) ? '0 : diff[W-1:0];

endmodule

// File: rtl/maxnet.sv
// MAXNET top: run-control FSM, activation registers, sum tree, iteration and
// survivor counters. result is a mask of neurons still nonzero at termination.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for start
// LOAD   | copy INIT into activations, clear iteration counter
// ITER   | check termination, else update all neurons in parallel
// DONE   | result valid, done high; start launches a new run
module maxnet
    import maxnet_pkg::*;
#(
    parameter int               N         = DEF_N,
    parameter int               W         = DEF_W,
    parameter int               EPS_SHIFT = DEF_EPS_SHIFT,
    parameter int               MAX_ITER  = DEF_MAX_ITER,
    parameter logic [N*W-1:0]   INIT      = DEF_INIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int SW  = W + 3;
    localparam int CW  = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);
    localparam int NZW = $clog2(N + 1);

    state_t          state_q;
    logic            done_q;
    logic [N-1:0]    result_q;
    logic [CW-1:0]   iter_q;
    logic [W-1:0]    a_q [N];
    logic [W-1:0]    a_d [N];

    logic [SW-1:0]   sum;
    logic [N-1:0]    nz_mask;
    logic [NZW-1:0]  nz_cnt;
    logic            terminate;

    // Sum of all activations, wide enough that N values of W bits cannot overflow.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum = sum + {{(SW-W){1'b0}}, a_q[i]};
        end
    end

    // Survivor mask and population count of nonzero activations.
    always_comb begin
        nz_mask = '0;
        nz_cnt  = '0;
        for (int i = 0; i < N; i++) begin
            nz_mask[i] = |a_q[i];
            nz_cnt     = nz_cnt + {{(NZW-1){1'b0}}, nz_mask[i]};
        end
    end

    assign terminate = (nz_cnt <= NZW'(1)) || (iter_q == CW'(MAX_ITER));

    for (genvar g = 0; g < N; g++) begin : g_neuron
        maxnet_neuron #(
            .W         (W),
            .SW        (SW),
            .EPS_SHIFT (EPS_SHIFT)
        ) u_neuron (
            .a_i      (a_q[g]),
            .sum_i    (sum),
            .a_next_o (a_d[g])
        );
    end

    // Run-control FSM with registered done/result and activation/counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            iter_q   <= '0;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < N; i++) begin
                        a_q[i] <= INIT[i*W +: W];
                    end
                    iter_q  <= '0;
                    state_q <= S_ITER;
                end
                S_ITER: begin
                    if (terminate) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        result_q <= nz_mask;
                    end else begin
                        for (int i = 0; i < N; i++) begin
                            a_q[i] <= a_d[i];
                        end
                        iter_q <= iter_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_maxnet.sv
// Bench for maxnet: several parameterised instances driven by directed steps,
// expected results queued from a behavioural model and checked on done.
module tb_maxnet;

    localparam int NI  = 8;
    localparam int EPS = 3;

    typedef struct {
        int         id;
        logic [4:0] res;
        int         lat;
    } exp_t;

    function automatic logic [39:0] rnd_init(input int seed);
        logic [39:0] v;
        int          x;
        v = '0;
        x = seed * 7919 + 12345;
        for (int i = 0; i < 5; i++) begin
            x = x * 1103515245 + 12345;
            v[i*8 +: 8] = x[23:16];
        end
        return v;
    endfunction

    localparam logic [39:0] INIT_DEF    = {8'd10, 8'd45, 8'd60, 8'd35, 8'd20};
    localparam logic [39:0] INIT_TIE    = {8'd0, 8'd0, 8'd10, 8'd50, 8'd50};
    localparam logic [39:0] INIT_SINGLE = {8'd40, 8'd0, 8'd0, 8'd0, 8'd0};

    logic       clk;
    logic       start_v [NI];
    logic       rst_v   [NI];
    logic       done_v  [NI];
    logic [4:0] res_v   [NI];

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    maxnet u_def (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .done(done_v[0]), .result(res_v[0])
    );
    maxnet #(.INIT(INIT_TIE), .MAX_ITER(63)) u_tie63 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .done(done_v[1]), .result(res_v[1])
    );
    maxnet #(.INIT(INIT_TIE), .MAX_ITER(3)) u_tie3 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .done(done_v[2]), .result(res_v[2])
    );
    maxnet #(.INIT(INIT_SINGLE)) u_single (
        .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .done(done_v[3]), .result(res_v[3])
    );
    for (genvar j = 0; j < 4; j++) begin : g_rnd
        maxnet #(.INIT(rnd_init(j))) u_rnd (
            .clk(clk), .rst(rst_v[4+j]), .start(start_v[4+j]), .done(done_v[4+j]), .result(res_v[4+j])
        );
    end

    // Behavioural reference: signed update with clamp, stop on <=1 survivor or iteration cap.
    function automatic void model(input logic [39:0] init, input int maxit,
                                  output logic [4:0] res, output int k);
        int a [5];
        int na [5];
        int s;
        int nz;
        for (int i = 0; i < 5; i++) a[i] = int'(init[i*8 +: 8]);
        k = 0;
        for (int step = 0; step < 1000; step++) begin
            nz = 0;
            s  = 0;
            for (int i = 0; i < 5; i++) begin
                if (a[i] != 0) nz++;
                s += a[i];
            end
            if (nz <= 1 || k == maxit) break;
            for (int i = 0; i < 5; i++) begin
                na[i] = a[i] - ((s - a[i]) >>> EPS);
                if (na[i] < 0) na[i] = 0;
            end
            for (int i = 0; i < 5; i++) a[i] = na[i];
            k++;
        end
        for (int i = 0; i < 5; i++) res[i] = (a[i] != 0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One run on instance id: queue expectation, pulse/hold start, wait for done, compare.
    task automatic run(input int id, input logic [39:0] init, input int maxit,
                       input logic use_ref, input logic [4:0] ref_res, input int hold,
                       input logic chk_prev, input logic [4:0] prev);
        exp_t       e;
        logic [4:0] mres;
        int         k;
        int         cyc;
        int         n;
        logic       got;
        model(init, maxit, mres, k);
        e.id  = id;
        e.res = use_ref ? ref_res : mres;
        e.lat = 2 + k;
        sb.push_back(e);

        @(negedge clk);
        start_v[id] = 1'b1;
        @(posedge clk);
        #1;
        n = 1;
        if (hold <= 1) start_v[id] = 1'b0;
        check($sformatf("done_low_on_start[%0d]", id), 32'(done_v[id]), 32'd0);
        if (chk_prev) check($sformatf("result_kept[%0d]", id), 32'(res_v[id]), 32'(prev));

        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            n++;
            if (n >= hold) start_v[id] = 1'b0;
            if (done_v[id]) got = 1'b1;
        end

        e = sb.pop_front();
        check($sformatf("done_seen[%0d]", e.id), 32'(got), 32'd1);
        check($sformatf("latency[%0d]", e.id), 32'(cyc), 32'(e.lat));
        check($sformatf("result[%0d]", e.id), 32'(res_v[e.id]), 32'(e.res));

        repeat (3) @(posedge clk);
        #1;
        check($sformatf("done_held[%0d]", e.id), 32'(done_v[e.id]), 32'd1);
        check($sformatf("result_held[%0d]", e.id), 32'(res_v[e.id]), 32'(e.res));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0;
            rst_v[i]   = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_done[%0d]", i), 32'(done_v[i]), 32'd0);
            check($sformatf("reset_result[%0d]", i), 32'(res_v[i]), 32'd0);
        end
        @(negedge clk);
        for (int i = 0; i < NI; i++) rst_v[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_start", 32'(done_v[0]), 32'd0);

        // Default INIT, start held three cycles: one run, winner neuron 2.
        run(0, INIT_DEF, 63, 1'b1, 5'b00100, 3, 1'b0, 5'b0);
        // Start pulsed in DONE: rerun with identical result, old result kept meanwhile.
        run(0, INIT_DEF, 63, 1'b1, 5'b00100, 1, 1'b1, 5'b00100);
        // Two-way tie, full iteration budget and a short budget.
        run(1, INIT_TIE, 63, 1'b0, 5'b0, 1, 1'b0, 5'b0);
        run(2, INIT_TIE, 3, 1'b0, 5'b0, 1, 1'b0, 5'b0);
        // Single nonzero neuron: no updates at all.
        run(3, INIT_SINGLE, 63, 1'b1, 5'b10000, 1, 1'b0, 5'b0);
        // Pseudo-random INIT sweep.
        for (int j = 0; j < 4; j++) begin
            run(4 + j, rnd_init(j), 63, 1'b0, 5'b0, 1, 1'b0, 5'b0);
        end

        // Reset in the middle of ITER aborts the run.
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_v[0]   = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_rst_done", 32'(done_v[0]), 32'd0);
        check("midrun_rst_result", 32'(res_v[0]), 32'd0);
        @(negedge clk);
        rst_v[0]   = 1'b0;
        start_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_waits", 32'(done_v[0]), 32'd0);
        run(0, INIT_DEF, 63, 1'b1, 5'b00100, 1, 1'b1, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
